// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder.
// Contents:
//   state_e  - controller states (idle, run, done)
//   steps_f  - number of digit steps needed to cover an operand
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit steps per operation; a zero digit width is rejected by the top-level
  // parameter check, so return a harmless value rather than divide by zero.
  function automatic int unsigned steps_f(input int unsigned width, input int unsigned digit);
    if (digit == 0) begin
      return 1;
    end
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice.
// Ports:
//   i_x, i_y     DIGIT-bit addends
//   i_carry      carry into bit 0
//   o_sum        DIGIT-bit sum
//   o_carry      carry out of the top bit
//   o_msb_carry  carry into the top bit (for signed overflow detection)
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_carry,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_carry,
  output logic             o_msb_carry
);

  always_comb begin
    logic [DIGIT:0] chain;
    chain    = '0;
    o_sum    = '0;
    chain[0] = i_carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      o_sum[i]   = i_x[i] ^ i_y[i] ^ chain[i];
      chain[i+1] = (i_x[i] & i_y[i]) | (chain[i] & (i_x[i] ^ i_y[i]));
    end
    o_carry     = chain[DIGIT];
    o_msb_carry = chain[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
// through a single registered carry. Valid/ready handshakes on input and output sides.
// Optional feature macro: ADDER_SUB_EN (adds i_sub; subtract X-Y when set at acceptance).
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  operand handshake; operands sampled only on the acceptance edge
//   i_x, i_y         operands
//   i_carry          carry-in
//   i_sub            (ADDER_SUB_EN only) subtract request
//   o_valid/i_ready  result handshake; results held while i_ready is low
//   o_sum            WIDTH-bit result (modulo 2^WIDTH)
//   o_carry          carry out of the MSB (for subtraction: 1 = no borrow)
//   o_overflow       signed overflow
//   o_busy           high while running or holding an unconsumed result
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
`ifdef ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int unsigned Steps = steps_f(WIDTH, DIGIT);
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
  end

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             carry_out_q;
  logic             ovf_out_q;
  logic             valid_q;
  logic             ready_q;
  logic             busy_q;

  // Operand conditioning at capture time.
  logic [WIDTH-1:0] y_cap;
  logic             cin_cap;

`ifdef ADDER_SUB_EN
  // Two's-complement subtract: X + ~Y + 1; the caller's carry-in is ignored.
  assign y_cap   = i_sub ? ~i_y : i_y;
  assign cin_cap = i_sub | i_carry;
`else
  assign y_cap   = i_y;
  assign cin_cap = i_carry;
`endif

  logic [DIGIT-1:0] slice_sum;
  logic             slice_carry;
  logic             slice_msb_carry;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_slice (
    .i_x        (x_q[DIGIT-1:0]),
    .i_y        (y_q[DIGIT-1:0]),
    .i_carry    (carry_q),
    .o_sum      (slice_sum),
    .o_carry    (slice_carry),
    .o_msb_carry(slice_msb_carry)
  );

  // Sum register fills from the top; after Steps shifts the first digit sits at bit 0.
  logic [WIDTH-1:0] sum_shift;

  if (DIGIT == WIDTH) begin : g_sum_single
    assign sum_shift = slice_sum;
  end else begin : g_sum_multi
    assign sum_shift = {slice_sum, sum_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_out_q   <= '0;
      carry_out_q <= 1'b0;
      ovf_out_q   <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid && ready_q) begin
            x_q     <= i_x;
            y_q     <= y_cap;
            carry_q <= cin_cap;
            cnt_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          x_q     <= x_q >> DIGIT;
          y_q     <= y_q >> DIGIT;
          sum_q   <= sum_shift;
          carry_q <= slice_carry;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Outputs update only here, so they survive the next operation's run phase.
            sum_out_q   <= sum_shift;
            carry_out_q <= slice_carry;
            ovf_out_q   <= slice_msb_carry ^ slice_carry;
            valid_q     <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_sum      = sum_out_q;
  assign o_carry    = carry_out_q;
  assign o_overflow = ovf_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases on WIDTH=8/DIGIT=2 plus randomized
// traffic with stalls on several WIDTH/DIGIT configurations, checked against an arithmetic model.
module tb_serial_adder;

  localparam int NCFG = 5;
  localparam int WS[NCFG] = '{8, 8, 8, 8, 16};
  localparam int DS[NCFG] = '{2, 1, 4, 8, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_i   [NCFG];
  logic        rdy_o [NCFG];
  logic [15:0] x_i   [NCFG];
  logic [15:0] y_i   [NCFG];
  logic        c_i   [NCFG];
  logic        sub_i [NCFG];
  logic        v_o   [NCFG];
  logic        r_i   [NCFG];
  logic [15:0] s_o   [NCFG];
  logic        co_o  [NCFG];
  logic        ov_o  [NCFG];
  logic        busy_o[NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int D = DS[g];
    logic [W-1:0] sum_w;
    serial_adder #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (v_i[g]),
      .o_ready   (rdy_o[g]),
      .i_x       (x_i[g][W-1:0]),
      .i_y       (y_i[g][W-1:0]),
      .i_carry   (c_i[g]),
`ifdef ADDER_SUB_EN
      .i_sub     (sub_i[g]),
`endif
      .o_valid   (v_o[g]),
      .i_ready   (r_i[g]),
      .o_sum     (sum_w),
      .o_carry   (co_o[g]),
      .o_overflow(ov_o[g]),
      .o_busy    (busy_o[g])
    );
    assign s_o[g] = 16'(sum_w);
  end

  // Reference: plain integer arithmetic on w-bit operands. Returns {ovf, carry, sum}.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic cin, input logic sub);
    logic [16:0] mask, xx, yy, full;
    logic [15:0] s;
    logic        c, carry, ovf;
    mask  = (17'd1 << w) - 17'd1;
    xx    = {1'b0, x} & mask;
    yy    = (sub ? {1'b0, ~y} : {1'b0, y}) & mask;
    c     = sub ? 1'b1 : cin;
    full  = xx + yy + 17'(c);
    s     = full[15:0] & mask[15:0];
    carry = full[w];
    ovf   = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
    return {ovf, carry, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation, then wait for o_valid. Garbage i_valid pulses are thrown at the DUT
  // while it runs; they must be ignored. Leaves the DUT holding its result.
  task automatic run_op(input int k, input logic [15:0] x, input logic [15:0] y, input logic cin,
                        input logic sub, output int lat, output bit tmo);
    int n = 0;
    tmo = 1'b0;
    lat = 0;
    while (!rdy_o[k] && n < 50) begin
      step();
      n++;
    end
    if (!rdy_o[k]) begin
      tmo = 1'b1;
      return;
    end
    x_i[k]   = x;
    y_i[k]   = y;
    c_i[k]   = cin;
    sub_i[k] = sub;
    v_i[k]   = 1'b1;
    step();
    while (!v_o[k] && lat < 100) begin
      v_i[k]   = 1'($urandom_range(0, 1));
      x_i[k]   = 16'($urandom);
      y_i[k]   = 16'($urandom);
      c_i[k]   = 1'($urandom_range(0, 1));
      sub_i[k] = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    v_i[k] = 1'b0;
    if (!v_o[k]) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      v_i[k] = 1'b0; r_i[k] = 1'b0; x_i[k] = '0; y_i[k] = '0; c_i[k] = 1'b0; sub_i[k] = 1'b0;
    end
    repeat (3) step();
    checks++;
    if (v_o[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v_o[0]); end
    checks++;
    if (s_o[0] !== 16'h0) begin errors++; $display("FAIL reset_sum got %h exp 0", s_o[0]); end
    checks++;
    if ({co_o[0], ov_o[0]} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b%b exp 00", co_o[0], ov_o[0]);
    end
    checks++;
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o[0]); end
    checks++;
    if (rdy_o[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_o[0]); end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] tx[4] = '{8'h35, 8'hFF, 8'h7F, 8'h00};
    logic [7:0] ty[4] = '{8'h4A, 8'h01, 8'h01, 8'h00};
    logic       tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ts[4] = '{8'h7F, 8'h00, 8'h80, 8'h01};
    logic       tco[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       tov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 16'(tx[i]), 16'(ty[i]), tc[i], 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 4) begin
        errors++; $display("FAIL dir%0d_latency got %0d (timeout %0d) exp 4", i, lat, tmo);
      end
      checks++;
      if (s_o[0] !== 16'(ts[i])) begin
        errors++; $display("FAIL dir%0d_sum got %h exp %h", i, s_o[0], ts[i]);
      end
      checks++;
      if ({co_o[0], ov_o[0]} !== {tco[i], tov[i]}) begin
        errors++;
        $display("FAIL dir%0d_flags got c%b v%b exp c%b v%b", i, co_o[0], ov_o[0], tco[i], tov[i]);
      end
      r_i[0] = 1'b1;
      step();
      r_i[0] = 1'b0;
      checks++;
      if (v_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
        errors++; $display("FAIL dir%0d_release got v%b r%b exp v0 r1", i, v_o[0], rdy_o[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    // C3 + 5A + 1 = 0x11E
    run_op(0, 16'h00C3, 16'h005A, 1'b1, 1'b0, lat, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL bp_start got timeout exp result"); end
    for (int i = 0; i < 5; i++) begin
      v_i[0] = 1'b1;
      x_i[0] = 16'($urandom);
      y_i[0] = 16'($urandom);
      step();
      checks++;
      if (v_o[0] !== 1'b1 || rdy_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b r%b b%b exp v1 r0 b1", i, v_o[0], rdy_o[0], busy_o[0]);
      end
      checks++;
      if (s_o[0] !== 16'h001E || co_o[0] !== 1'b1 || ov_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable%0d got %h c%b v%b exp 1e c1 v0", i, s_o[0], co_o[0], ov_o[0]);
      end
    end
    // i_valid stays high across the release edge: it must not be taken in the same cycle.
    x_i[0] = 16'h0001;
    y_i[0] = 16'h0002;
    c_i[0] = 1'b0;
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
    checks++;
    if (rdy_o[0] !== 1'b1 || v_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bypass got r%b v%b b%b exp r1 v0 b0", rdy_o[0], v_o[0], busy_o[0]);
    end
    checks++;
    if (s_o[0] !== 16'h001E) begin errors++; $display("FAIL bp_keep got %h exp 1e", s_o[0]); end
    step();
    v_i[0] = 1'b0;
    checks++;
    if (busy_o[0] !== 1'b1 || rdy_o[0] !== 1'b0) begin
      errors++; $display("FAIL bp_accept got b%b r%b exp b1 r0", busy_o[0], rdy_o[0]);
    end
    lat = 0;
    while (!v_o[0] && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (v_o[0] !== 1'b1 || lat != 4 || s_o[0] !== 16'h0003) begin
      errors++; $display("FAIL bp_second got v%b lat %0d sum %h exp v1 lat 4 sum 03", v_o[0], lat,
                         s_o[0]);
    end
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat;
    bit tmo;
    run_op(0, 16'h0035, 16'h004A, 1'b0, 1'b0, lat, tmo);
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
    x_i[0] = 16'h00AA;
    y_i[0] = 16'h0055;
    c_i[0] = 1'b0;
    v_i[0] = 1'b1;
    step();
    v_i[0] = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o[0] !== 1'b0 || v_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_ctrl got b%b v%b r%b exp b0 v0 r1", busy_o[0], v_o[0], rdy_o[0]);
    end
    checks++;
    if (s_o[0] !== 16'h0 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL areset_data got %h c%b v%b exp 0 c0 v0", s_o[0], co_o[0], ov_o[0]);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    run_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, lat, tmo);
    checks++;
    if (tmo || lat != 4 || s_o[0] !== 16'h0046) begin
      errors++;
      $display("FAIL areset_next got sum %h lat %0d tmo %0d exp sum 46 lat 4", s_o[0], lat, tmo);
    end
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    bit tmo;
    run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b1, lat, tmo);
    checks++;
    if (tmo || s_o[0] !== 16'h00F0 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL sub_a got %h c%b v%b exp f0 c0 v0", s_o[0], co_o[0], ov_o[0]);
    end
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
    run_op(0, 16'h0080, 16'h0001, 1'b0, 1'b1, lat, tmo);
    checks++;
    if (tmo || s_o[0] !== 16'h007F || co_o[0] !== 1'b1 || ov_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sub_b got %h c%b v%b exp 7f c1 v1", s_o[0], co_o[0], ov_o[0]);
    end
    r_i[0] = 1'b1;
    step();
    r_i[0] = 1'b0;
  endtask
`endif

  task automatic test_random(input int k, input int nops);
    int          w = WS[k];
    int          steps = WS[k] / DS[k];
    int          lat;
    bit          tmo;
    logic [15:0] x, y;
    logic        cin, sub;
    logic [17:0] exp_r;
    int          bad = 0;
    for (int n = 0; n < nops; n++) begin
      repeat ($urandom_range(0, 3)) step();
      x   = 16'($urandom);
      y   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      exp_r = ref_add(w, x, y, cin, sub);
      run_op(k, x, y, cin, sub, lat, tmo);
      checks++;
      if (tmo || lat != steps) begin
        errors++; bad++;
        $display("FAIL rnd%0d_latency op %0d got %0d tmo %0d exp %0d", k, n, lat, tmo, steps);
      end
      repeat ($urandom_range(0, 3)) step();
      checks++;
      if (v_o[k] !== 1'b1 || {ov_o[k], co_o[k], s_o[k]} !== exp_r) begin
        errors++; bad++;
        $display("FAIL rnd%0d_result op %0d x %h y %h c %b got v%b %h c%b o%b exp %h c%b o%b", k,
                 n, x, y, cin, v_o[k], s_o[k], co_o[k], ov_o[k], exp_r[15:0], exp_r[16],
                 exp_r[17]);
      end
      r_i[k] = 1'b1;
      step();
      r_i[k] = 1'b0;
      checks++;
      if (v_o[k] !== 1'b0) begin
        errors++; bad++; $display("FAIL rnd%0d_dup op %0d got v%b exp 0", k, n, v_o[k]);
      end
      if (bad > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    for (int k = 0; k < NCFG; k++) test_random(k, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation time limit");
  end

endmodule
